viterbi_link_ctrl: RTL
======================

// Module: viterbi_link_ctrl
// PURPOSE
//  Frame sequencer and channel scheduler for the encoder -> channel -> Viterbi decoder link.
//  Pulls payload bits from a source and drives the convolutional encoder enable/data.
//  Appends tail zeros and flush bits, and injects scheduled symbol errors on the 2-bit channel.
//  Gates the decoder enable, then scores decoded bits against a latency-matched copy of the payload.
// PARAMETERS
//  FRAME_LEN   256    payload bits per frame (>=1)
//  TAIL_LEN    2      zero tail bits (K-1) appended to terminate the trellis
//  FLUSH_LEN   16     extra zero bits so decoder traceback emits all payload bits
//  DEC_LAT     20     cycles from enc_en_o/enc_bit_o = b to dec_bit_i = b (end-to-end, fixed)
//  ERR_N       3      inject once every 2**ERR_N channel symbols
//  ERR_WINDOW  256    injection only while sym_ct < ERR_WINDOW
//  ERR_MASK    2'b01  XOR mask applied to an injected symbol
//  CW          16     width of all counters
// PORTS
//  clk          in   1   rising-edge clock
//  rst          in   1   synchronous, active-high reset
//  start_i      in   1   pulse: begin a frame (ignored unless IDLE or DONE)
//  inj_en_i     in   1   enable error injection for the frame (sampled at start)
//  pay_vld_i    in   1   payload source has a bit
//  pay_bit_i    in   1   payload bit
//  pay_rdy_o    out  1   pop strobe to source (= pay_vld_i & in RUN)
//  enc_en_o     out  1   encoder enable
//  enc_bit_o    out  1   encoder data in
//  enc_sym_i    in   2   encoder output symbol
//  enc_vld_i    in   1   encoder output valid
//  chan_sym_o   out  2   (possibly corrupted) symbol to decoder, registered
//  dec_en_o     out  1   decoder enable, registered enc_vld_i, 1-cycle latency
//  dec_bit_i    in   1   decoder output bit
//  busy_o       out  1   state != IDLE && state != DONE
//  done_o       out  1   high while state == DONE
//  inj_ct_o     out  CW  symbols corrupted this frame
//  bit_err_o    out  CW  payload bits decoded wrongly this frame
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; counters, delay line and inj flag cleared. Reset
//   mid-frame aborts immediately; no partial results are kept.
//  FSM: IDLE -start_i-> RUN. RUN: each cycle with pay_vld_i=1, enc_en_o=1,
//   enc_bit_o=pay_bit_i, and pay_ct++. Cycles with pay_vld_i=0 drive enc_en_o=0
//   (the stall stretches the frame). After pay_ct==FRAME_LEN -> TAIL.
//   TAIL: enc_en_o=1, enc_bit_o=0 for TAIL_LEN cycles -> FLUSH.
//   FLUSH: same for FLUSH_LEN cycles -> DRAIN.
//   DRAIN: enc_en_o=0 for DEC_LAT cycles -> DONE.
//   DONE: counters hold. start_i -> RUN, with counters cleared on that edge.
//  start_i in RUN/TAIL/FLUSH/DRAIN is ignored. A start_i in the same cycle as rst loses.
//  Channel: on an enc_vld_i cycle, inject = inj_en_q && sym_ct<ERR_WINDOW &&
//   sym_ct[ERR_N-1:0]=='1. Then chan_sym_o <= enc_sym_i ^ (inject ? ERR_MASK : 0),
//   and inj_ct++ if inject. sym_ct++ on each enc_vld_i cycle, saturating at all-ones.
//   When enc_vld_i=0, chan_sym_o holds its value.
//  Scoring: shift register of depth DEC_LAT carrying {tag, bit}. Tag=1 only for
//   payload bits (not tail/flush). When the tag emerges and dec_bit_i != bit,
//   bit_err++. Scoring continues through DRAIN. All counters saturate at 2**CW-1
//   and never wrap.
//  TAIL_LEN=0 or FLUSH_LEN=0 skips that state in zero cycles (no dead cycle).
//  FRAME_LEN=1 is legal.
// TESTING
//  1 inj_en_i=0, 256 random bits, source always valid
//    -> done after 256+2+16+20 cycles, inj_ct=0, bit_err=0.
//  2 inj_en_i=1, ERR_N=3, ERR_WINDOW=256
//    -> inj_ct=32, corrupted symbols at sym_ct 7,15,...,255 with bit0 flipped,
//       bit_err=0 with the team decoder.
//  3 pay_vld_i toggles every other cycle
//    -> enc_en_o mirrors it in RUN, 256 pops exactly, results identical to test 1.
//  4 rst asserted mid-RUN at pay_ct=100 -> next cycle IDLE, all outputs 0;
//    a fresh start completes normally.
//  5 start_i pulsed during FLUSH and DRAIN -> ignored; a pulse in DONE restarts
//    with inj_ct/bit_err cleared.
//  6 Decoder stub forced to invert dec_bit_i -> bit_err=FRAME_LEN; tail/flush bits
//    are not counted.

Source files
------------

// File: rtl/viterbi_link_ctrl_if.sv
// Encoder/channel/decoder link bundle. Signal names are given from the controller's side,
// so "_i" marks what the controller receives and "_o" marks what it drives.
interface viterbi_link_ctrl_if;
    logic       pay_vld_i;
    logic       pay_bit_i;
    logic       pay_rdy_o;
    logic       enc_en_o;
    logic       enc_bit_o;
    logic [1:0] enc_sym_i;
    logic       enc_vld_i;
    logic [1:0] chan_sym_o;
    logic       dec_en_o;
    logic       dec_bit_i;

    modport slave (
        input  pay_vld_i, pay_bit_i, enc_sym_i, enc_vld_i, dec_bit_i,
        output pay_rdy_o, enc_en_o, enc_bit_o, chan_sym_o, dec_en_o
    );

    modport master (
        output pay_vld_i, pay_bit_i, enc_sym_i, enc_vld_i, dec_bit_i,
        input  pay_rdy_o, enc_en_o, enc_bit_o, chan_sym_o, dec_en_o
    );
endinterface

// File: rtl/viterbi_link_ctrl.sv
// Frame sequencer for the encoder -> channel -> Viterbi link: feeds payload plus tail/flush
// zeros, corrupts scheduled channel symbols and scores decoded bits against a delayed copy.
module viterbi_link_ctrl #(
    parameter int         FRAME_LEN  = 256,
    parameter int         TAIL_LEN   = 2,
    parameter int         FLUSH_LEN  = 16,
    parameter int         DEC_LAT    = 20,
    parameter int         ERR_N      = 3,
    parameter int         ERR_WINDOW = 256,
    parameter logic [1:0] ERR_MASK   = 2'b01,
    parameter int         CW         = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 inj_en_i,
    viterbi_link_ctrl_if.slave   lnk,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [CW-1:0]        inj_ct_o,
    output logic [CW-1:0]        bit_err_o
);

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_TAIL, S_FLUSH, S_DRAIN, S_DONE} state_e;

    // Zero-length tail/flush phases are bypassed at elaboration so no dead cycle appears.
    localparam state_e AFTER_TAIL = (FLUSH_LEN > 0) ? S_FLUSH : S_DRAIN;
    localparam state_e AFTER_RUN  = (TAIL_LEN > 0) ? S_TAIL : AFTER_TAIL;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + CW'(1);
    endfunction

    state_e        state_q, state_d;
    logic [CW-1:0] pay_ct_q, pay_ct_d;
    logic [CW-1:0] ph_ct_q, ph_ct_d;
    logic [CW-1:0] sym_ct_q, inj_ct_q, err_ct_q;
    logic          inj_en_q;
    logic [1:0]    chan_q;
    logic          dec_en_q;
    logic [1:0]    dly_q [DEC_LAT];   // {tag, bit}; tag marks payload bits only

    logic enc_en, enc_bit, pay_rdy, clr;
    logic inject, err_hit;

    always_comb begin
        state_d  = state_q;
        pay_ct_d = pay_ct_q;
        ph_ct_d  = ph_ct_q;
        enc_en   = 1'b0;
        enc_bit  = 1'b0;
        pay_rdy  = 1'b0;
        clr      = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d = S_RUN;
                    clr     = 1'b1;
                end
            end
            S_RUN: begin
                pay_rdy = lnk.pay_vld_i;
                enc_en  = lnk.pay_vld_i;
                enc_bit = lnk.pay_vld_i & lnk.pay_bit_i;
                if (lnk.pay_vld_i) begin
                    pay_ct_d = sat_inc(pay_ct_q);
                    if (pay_ct_q == CW'(FRAME_LEN - 1)) begin
                        state_d = AFTER_RUN;
                        ph_ct_d = '0;
                    end
                end
            end
            S_TAIL: begin
                enc_en = 1'b1;
                if (ph_ct_q == CW'(TAIL_LEN - 1)) begin
                    state_d = AFTER_TAIL;
                    ph_ct_d = '0;
                end else begin
                    ph_ct_d = ph_ct_q + CW'(1);
                end
            end
            S_FLUSH: begin
                enc_en = 1'b1;
                if (ph_ct_q == CW'(FLUSH_LEN - 1)) begin
                    state_d = S_DRAIN;
                    ph_ct_d = '0;
                end else begin
                    ph_ct_d = ph_ct_q + CW'(1);
                end
            end
            S_DRAIN: begin
                if (ph_ct_q == CW'(DEC_LAT - 1)) begin
                    state_d = S_DONE;
                    ph_ct_d = '0;
                end else begin
                    ph_ct_d = ph_ct_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (clr) begin
            pay_ct_d = '0;
            ph_ct_d  = '0;
        end
    end

    assign inject  = inj_en_q && (32'(sym_ct_q) < ERR_WINDOW) && (&sym_ct_q[ERR_N-1:0]);
    assign err_hit = dly_q[DEC_LAT-1][1] && (lnk.dec_bit_i != dly_q[DEC_LAT-1][0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pay_ct_q <= '0;
            ph_ct_q  <= '0;
            sym_ct_q <= '0;
            inj_ct_q <= '0;
            err_ct_q <= '0;
            inj_en_q <= 1'b0;
            chan_q   <= 2'b00;
            dec_en_q <= 1'b0;
            for (int i = 0; i < DEC_LAT; i++) dly_q[i] <= 2'b00;
        end else begin
            state_q  <= state_d;
            pay_ct_q <= pay_ct_d;
            ph_ct_q  <= ph_ct_d;
            dec_en_q <= lnk.enc_vld_i;
            if (lnk.enc_vld_i) chan_q <= lnk.enc_sym_i ^ (inject ? ERR_MASK : 2'b00);
            for (int i = DEC_LAT - 1; i > 0; i--) dly_q[i] <= dly_q[i-1];
            dly_q[0] <= {pay_rdy, enc_bit};
            if (clr) begin
                sym_ct_q <= '0;
                inj_ct_q <= '0;
                err_ct_q <= '0;
                inj_en_q <= inj_en_i;
            end else begin
                if (lnk.enc_vld_i) begin
                    sym_ct_q <= sat_inc(sym_ct_q);
                    if (inject) inj_ct_q <= sat_inc(inj_ct_q);
                end
                if (err_hit) err_ct_q <= sat_inc(err_ct_q);
            end
        end
    end

    assign lnk.pay_rdy_o  = pay_rdy;
    assign lnk.enc_en_o   = enc_en;
    assign lnk.enc_bit_o  = enc_bit;
    assign lnk.chan_sym_o = chan_q;
    assign lnk.dec_en_o   = dec_en_q;
    assign busy_o         = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done_o         = (state_q == S_DONE);
    assign inj_ct_o       = inj_ct_q;
    assign bit_err_o      = err_ct_q;

endmodule
